// File: rtl/rans_pkg.sv
// Shared definitions for the parametrised rANS decoder: FSM state encoding and
// helpers deriving the renormalisation bound and the init chunk count.
package rans_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOOKUP,
    EMIT,
    UPDATE,
    RENORM,
    DONE
  } rans_state_t;

  function automatic int chunk_count(input int state_width, input int io_width);
    return state_width / io_width;
  endfunction

  function automatic logic [63:0] low_bound(input int state_width, input int io_width);
    return 64'(1) << (state_width - io_width);
  endfunction

endpackage

// File: rtl/rans_icdf_lookup.sv
// Inverse-CDF lookup: finds the largest symbol whose cumulative start is <= slot,
// either with one parallel compare or by scanning one table entry per cycle.
module rans_icdf_lookup
  import rans_pkg::*;
#(
  parameter int SYM_WIDTH       = 4,
  parameter int SYM_COUNT       = 16,
  parameter int PROB_BITS       = 8,
  parameter int PARALLEL_LOOKUP = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [PROB_BITS-1:0]               slot,
  input  logic [(PROB_BITS+1)*SYM_COUNT-1:0] freq_unpacked,
  input  logic [PROB_BITS*SYM_COUNT-1:0]     cum_unpacked,
  output logic [SYM_WIDTH-1:0]               sym,
  output logic                               hit_err,
  output logic                               done
);

  logic [PROB_BITS-1:0] cum_t  [SYM_COUNT];
  logic [PROB_BITS:0]   freq_t [SYM_COUNT];
  logic [PROB_BITS+1:0] upper;

  for (genvar g = 0; g < SYM_COUNT; g++) begin : g_tab
    assign cum_t[g]  = cum_unpacked[g*PROB_BITS +: PROB_BITS];
    assign freq_t[g] = freq_unpacked[g*(PROB_BITS+1) +: (PROB_BITS+1)];
  end

  // A slot past the end of the chosen symbol's range means the tables are inconsistent.
  assign upper   = {2'b00, cum_t[sym]} + {1'b0, freq_t[sym]};
  assign hit_err = {2'b00, slot} >= upper;

  if (PARALLEL_LOOKUP != 0) begin : g_par
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
      sym = '0;
      for (int s = 0; s < SYM_COUNT; s++) begin
        if (cum_t[s] <= slot) sym = SYM_WIDTH'(s);
      end
    end

    assign done = start;
  end else begin : g_ser
    logic                 running;
    logic [SYM_WIDTH-1:0] idx;
    logic [PROB_BITS-1:0] next_cum;
    logic                 last;

    // start is held for the whole lookup; the scan restarts from entry 0 each time.
    assign sym  = running ? idx : '0;
    assign last = (int'(sym) == SYM_COUNT - 1);

    always_comb begin
      next_cum = '1;
      for (int s = 0; s < SYM_COUNT - 1; s++) begin
        if (int'(sym) == s) next_cum = cum_t[s+1];
      end
    end

    assign done = start && (last || (next_cum > slot));

    always_ff @(posedge clk) begin
      if (rst) begin
        running <= 1'b0;
        idx     <= '0;
      end else if (start && !done) begin
        running <= 1'b1;
        idx     <= sym + 1'b1;
      end else begin
        running <= 1'b0;
        idx     <= '0;
      end
    end
  end

endmodule

// File: rtl/rans_decoder_param.sv
// Parametrised rANS decoder with power-of-two total frequency, frame control,
// valid/ready streams on input chunks and output symbols, and a sticky table error.
module rans_decoder_param
  import rans_pkg::*;
#(
  parameter int SYM_WIDTH       = 4,
  parameter int SYM_COUNT       = 16,
  parameter int PROB_BITS       = 8,
  parameter int STATE_WIDTH     = 32,
  parameter int IO_WIDTH        = 4,
  parameter int LEN_WIDTH       = 16,
  parameter int PARALLEL_LOOKUP = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [LEN_WIDTH-1:0]               num_syms,
  input  logic [(PROB_BITS+1)*SYM_COUNT-1:0] freq_unpacked,
  input  logic [PROB_BITS*SYM_COUNT-1:0]     cum_unpacked,
  input  logic [IO_WIDTH-1:0]                in_data,
  input  logic                               in_vld,
  output logic                               in_rdy,
  output logic [SYM_WIDTH-1:0]               out_sym,
  output logic                               out_vld,
  input  logic                               out_rdy,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [STATE_WIDTH-1:0]             final_state
);

  localparam int CHUNKS = chunk_count(STATE_WIDTH, IO_WIDTH);
  localparam int CW     = $clog2(CHUNKS + 1);
  localparam logic [STATE_WIDTH-1:0] L_BOUND = STATE_WIDTH'(low_bound(STATE_WIDTH, IO_WIDTH));

  rans_state_t            state;
  logic [STATE_WIDTH-1:0] x;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [CW-1:0]          chunk_cnt;

  logic [PROB_BITS-1:0]   slot;
  logic [STATE_WIDTH-1:0] x_shift;
  logic [STATE_WIDTH-1:0] x_upd;
  logic [PROB_BITS:0]     freq_s;
  logic [PROB_BITS-1:0]   cum_s;
  logic [SYM_WIDTH-1:0]   lk_sym;
  logic                   lk_err;
  logic                   lk_done;

  assign slot    = x[PROB_BITS-1:0];
  assign x_shift = {x[STATE_WIDTH-IO_WIDTH-1:0], in_data};

  // out_sym holds the symbol chosen by the last lookup, so UPDATE indexes the tables with it.
  assign freq_s = freq_unpacked[out_sym*(PROB_BITS+1) +: (PROB_BITS+1)];
  assign cum_s  = cum_unpacked[out_sym*PROB_BITS +: PROB_BITS];
  assign x_upd  = STATE_WIDTH'(freq_s) * (x >> PROB_BITS) + STATE_WIDTH'(slot) - STATE_WIDTH'(cum_s);

  rans_icdf_lookup #(
    .SYM_WIDTH      (SYM_WIDTH),
    .SYM_COUNT      (SYM_COUNT),
    .PROB_BITS      (PROB_BITS),
    .PARALLEL_LOOKUP(PARALLEL_LOOKUP)
  ) u_lookup (
    .clk          (clk),
    .rst          (rst),
    .start        (state == LOOKUP),
    .slot         (slot),
    .freq_unpacked(freq_unpacked),
    .cum_unpacked (cum_unpacked),
    .sym          (lk_sym),
    .hit_err      (lk_err),
    .done         (lk_done)
  );

  assign in_rdy      = (state == INIT) || (state == RENORM);
  assign out_vld     = (state == EMIT);
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign final_state = x;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x         <= '0;
      remaining <= '0;
      chunk_cnt <= '0;
      out_sym   <= '0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (num_syms != '0) begin
              x         <= '0;
              remaining <= num_syms;
              chunk_cnt <= '0;
              state     <= INIT;
            end else begin
              state <= DONE;
            end
          end
        end
        INIT: begin
          if (in_vld) begin
            x         <= x_shift;
            chunk_cnt <= chunk_cnt + 1'b1;
            if (chunk_cnt == CW'(CHUNKS - 1)) state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lk_done) begin
            out_sym <= lk_sym;
            if (lk_err) err <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_rdy) state <= UPDATE;
        end
        UPDATE: begin
          x         <= x_upd;
          remaining <= remaining - 1'b1;
          // The last symbol ends the frame without pulling renormalisation chunks.
          if (remaining == LEN_WIDTH'(1)) state <= DONE;
          else if (x_upd < L_BOUND)       state <= RENORM;
          else                            state <= LOOKUP;
        end
        RENORM: begin
          if (in_vld) begin
            x <= x_shift;
            if (x_shift >= L_BOUND) state <= LOOKUP;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rans_decoder_param.sv
// Directed frames on a parallel and a serial decoder instance; expected symbols and
// frame results go into queues that an independent monitor pops as outputs appear.
module tb_rans_decoder_param;

  localparam int SW = 2, SC = 4, PB = 4, STW = 16, IOW = 4, LW = 16, CHUNKS = 4;

  typedef struct {
    logic [STW-1:0] fs;
    logic           err;
    logic           check_fs;
    int             chunks_end;
  } frame_t;

  logic clk = 1'b0;
  logic rst, start, in_vld, out_rdy, sel_ser;
  logic [LW-1:0] num_syms;
  logic [IOW-1:0] in_data;
  logic [(PB+1)*SC-1:0] freq_unpacked;
  logic [PB*SC-1:0] cum_unpacked;

  logic in_rdy, out_vld, busy, done, err;
  logic [SW-1:0] out_sym;
  logic [STW-1:0] final_state;

  logic start_p, start_s, vld_p, vld_s;
  logic in_rdy_p, out_vld_p, busy_p, done_p, err_p;
  logic in_rdy_s, out_vld_s, busy_s, done_s, err_s;
  logic [SW-1:0] out_sym_p, out_sym_s;
  logic [STW-1:0] final_state_p, final_state_s;

  int total = 0;
  int bad = 0;
  int chunk_total = 0;
  int frames_done = 0;

  logic [SW-1:0] exp_sym_q[$];
  frame_t frame_q[$];
  logic [IOW-1:0] chunk_plan[$];
  logic [SW-1:0] sym_plan[$];

  always #5 clk = ~clk;

  assign start_p = start & ~sel_ser;
  assign start_s = start & sel_ser;
  assign vld_p   = in_vld & ~sel_ser;
  assign vld_s   = in_vld & sel_ser;

  assign in_rdy      = sel_ser ? in_rdy_s      : in_rdy_p;
  assign out_vld     = sel_ser ? out_vld_s     : out_vld_p;
  assign busy        = sel_ser ? busy_s        : busy_p;
  assign done        = sel_ser ? done_s        : done_p;
  assign err         = sel_ser ? err_s         : err_p;
  assign out_sym     = sel_ser ? out_sym_s     : out_sym_p;
  assign final_state = sel_ser ? final_state_s : final_state_p;

  rans_decoder_param #(
    .SYM_WIDTH(SW), .SYM_COUNT(SC), .PROB_BITS(PB), .STATE_WIDTH(STW),
    .IO_WIDTH(IOW), .LEN_WIDTH(LW), .PARALLEL_LOOKUP(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start_p), .num_syms(num_syms),
    .freq_unpacked(freq_unpacked), .cum_unpacked(cum_unpacked),
    .in_data(in_data), .in_vld(vld_p), .in_rdy(in_rdy_p),
    .out_sym(out_sym_p), .out_vld(out_vld_p), .out_rdy(out_rdy),
    .busy(busy_p), .done(done_p), .err(err_p), .final_state(final_state_p)
  );

  rans_decoder_param #(
    .SYM_WIDTH(SW), .SYM_COUNT(SC), .PROB_BITS(PB), .STATE_WIDTH(STW),
    .IO_WIDTH(IOW), .LEN_WIDTH(LW), .PARALLEL_LOOKUP(0)
  ) dut_ser (
    .clk(clk), .rst(rst), .start(start_s), .num_syms(num_syms),
    .freq_unpacked(freq_unpacked), .cum_unpacked(cum_unpacked),
    .in_data(in_data), .in_vld(vld_s), .in_rdy(in_rdy_s),
    .out_sym(out_sym_s), .out_vld(out_vld_s), .out_rdy(out_rdy),
    .busy(busy_s), .done(done_s), .err(err_s), .final_state(final_state_s)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tables(input int f0, input int f1, input int f2, input int f3);
    freq_unpacked = {5'(f3), 5'(f2), 5'(f1), 5'(f0)};
    cum_unpacked  = {4'd14, 4'd12, 4'd8, 4'd0};
  endtask

  task automatic pulse_start(input logic [LW-1:0] n);
    num_syms = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [IOW-1:0] d);
    int k;
    k = 0;
    in_data = d;
    in_vld = 1'b1;
    @(negedge clk);
    while (!in_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("chunk_accepted", in_rdy, 1);
    tick();
    in_vld = 1'b0;
  endtask

  // Runs one frame from chunk_plan/sym_plan; also times the first lookup after INIT.
  task automatic applyStimulus(input int n, input logic [STW-1:0] exp_fs, input logic exp_err,
                               input int exp_lat);
    frame_t f;
    int k, lat, base_done;
    foreach (sym_plan[i]) exp_sym_q.push_back(sym_plan[i]);
    f.fs = exp_fs;
    f.err = exp_err;
    f.check_fs = 1'b1;
    f.chunks_end = chunk_total + chunk_plan.size();
    frame_q.push_back(f);
    base_done = frames_done;
    pulse_start(LW'(n));
    checkOutput("busy_after_start", busy, 1);
    for (int i = 0; i < chunk_plan.size(); i++) begin
      send_chunk(chunk_plan[i]);
      if (i == CHUNKS - 1) begin
        lat = 0;
        while (!out_vld && lat < 64) begin
          tick();
          lat++;
        end
        checkOutput("lookup_latency", lat, exp_lat);
      end
    end
    k = 0;
    while (frames_done == base_done && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput("frame_done_seen", 32'(frames_done - base_done), 1);
    tick();
  endtask

  always @(negedge clk) begin : monitor
    frame_t f;
    logic [SW-1:0] es;
    if (!rst) begin
      if (in_vld && in_rdy) chunk_total++;
      if (out_vld && out_rdy) begin
        if (exp_sym_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sym_unexpected: got symbol %0h, expected none", out_sym);
        end else begin
          es = exp_sym_q.pop_front();
          checkOutput("out_sym", out_sym, es);
        end
      end
      if (done) begin
        frames_done++;
        checkOutput("busy_at_done", busy, 0);
        if (frame_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL done_unexpected: got done, expected none");
        end else begin
          f = frame_q.pop_front();
          if (f.check_fs) checkOutput("final_state", final_state, f.fs);
          checkOutput("err_at_done", err, f.err);
          checkOutput("chunks_consumed", chunk_total, f.chunks_end);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_data = '0; num_syms = '0;
    out_rdy = 1'b1; sel_ser = 1'b0;
    set_tables(8, 4, 2, 2);
    repeat (2) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_in_rdy", in_rdy, 0);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_final_state", final_state, 0);
    checkOutput("rst_out_sym", out_sym, 0);
    rst = 1'b0;
    tick();

    $display("[TB] basic decode");
    chunk_plan = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
    sym_plan = '{2'd0, 2'd1};
    applyStimulus(2, 16'h2472, 1'b0, 1);

    $display("[TB] start while busy is ignored");
    fork
      applyStimulus(2, 16'h2472, 1'b0, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        num_syms = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    join

    $display("[TB] backpressure");
    out_rdy = 1'b0;
    fork
      applyStimulus(2, 16'h2472, 1'b0, 1);
      begin
        k = 0;
        @(negedge clk);
        while (!out_vld && k < 100) begin
          @(negedge clk);
          k++;
        end
        checkOutput("bp_vld_seen", out_vld, 1);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          checkOutput("bp_hold_sym", out_sym, 0);
          checkOutput("bp_hold_vld", out_vld, 1);
          checkOutput("bp_in_rdy", in_rdy, 0);
        end
        tick();
        out_rdy = 1'b1;
      end
    join

    $display("[TB] slot 14, parallel then serial");
    chunk_plan = '{4'h0, 4'h0, 4'hF, 4'hE};
    sym_plan = '{2'd3};
    applyStimulus(1, 16'h001E, 1'b0, 1);
    sel_ser = 1'b1;
    tick();
    applyStimulus(1, 16'h001E, 1'b0, 4);
    chunk_plan = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
    sym_plan = '{2'd0, 2'd1};
    applyStimulus(2, 16'h2472, 1'b0, 1);
    sel_ser = 1'b0;
    tick();

    $display("[TB] table error");
    set_tables(8, 4, 2, 0);
    chunk_plan = '{4'h0, 4'h0, 4'h0, 4'hF};
    sym_plan = '{2'd3};
    applyStimulus(1, 16'h0001, 1'b1, 1);
    repeat (3) tick();
    checkOutput("err_sticky", err, 1);

    $display("[TB] zero-length frame");
    begin
      frame_t f;
      f.fs = '0;
      f.err = 1'b0;
      f.check_fs = 1'b0;
      f.chunks_end = chunk_total;
      frame_q.push_back(f);
    end
    pulse_start(16'd0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    checkOutput("zero_in_rdy", in_rdy, 0);
    checkOutput("zero_err_cleared", err, 0);
    tick();
    checkOutput("zero_done_pulse", done, 0);
    checkOutput("zero_in_rdy_after", in_rdy, 0);

    $display("[TB] reset during renorm");
    set_tables(8, 4, 2, 2);
    exp_sym_q.push_back(2'd0);
    pulse_start(16'd2);
    for (int i = 0; i < CHUNKS; i++) send_chunk(IOW'(i + 1));
    k = 0;
    while (!in_rdy && k < 50) begin
      tick();
      k++;
    end
    checkOutput("renorm_reached", in_rdy, 1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_in_rdy", in_rdy, 0);
    checkOutput("midrst_out_vld", out_vld, 0);
    checkOutput("midrst_done", done, 0);
    rst = 1'b0;
    checkOutput("midrst_sym_q_empty", exp_sym_q.size(), 0);
    tick();
    chunk_plan = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA};
    sym_plan = '{2'd0, 2'd1};
    applyStimulus(2, 16'h2472, 1'b0, 1);

    repeat (3) tick();
    checkOutput("sym_q_drained", exp_sym_q.size(), 0);
    checkOutput("frame_q_drained", frame_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
